// File: rtl/regfile_pkg.sv
// Shared types, sizes and read-mux helpers for the LEGv8 write-back register file.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned ZERO_REG   = 31;

    typedef logic [ADDR_WIDTH-1:0]                reg_idx_t;
    typedef logic [DATA_WIDTH-1:0]                word_t;
    typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  word_vec_t;

    function automatic word_t mux4to1_64(input word_t a, input word_t b,
                                         input word_t c, input word_t d,
                                         input logic [1:0] s);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    // 32:1 read mux as two 4:1 levels followed by a final 2:1 on the index MSB.
    function automatic word_t mux32to1_64(input word_vec_t d, input reg_idx_t sel);
        word_t l1 [8];
        word_t l2 [2];
        for (int i = 0; i < 8; i++) begin
            l1[i] = mux4to1_64(d[4*i], d[4*i+1], d[4*i+2], d[4*i+3], sel[1:0]);
        end
        for (int i = 0; i < 2; i++) begin
            l2[i] = mux4to1_64(l1[4*i], l1[4*i+1], l1[4*i+2], l1[4*i+3], sel[3:2]);
        end
        return sel[4] ? l2[1] : l2[0];
    endfunction

endpackage

// File: rtl/regfile_wb_decoder5to32.sv
// 5-to-32 one-hot write-enable decoder: a 2-to-4 stage on addr[4:3] enabling four 3-to-8 stages.
module regfile_wb_decoder5to32
    import regfile_pkg::*;
(
    input  logic                write_i,
    input  reg_idx_t            addr_i,
    output logic [NUM_REGS-1:0] out_o
);

    logic [3:0] bank_en_c;

    always_comb begin
        bank_en_c = '0;
        out_o     = '0;
        if (write_i) begin
            bank_en_c = 4'(1) << addr_i[4:3];
        end
        for (int unsigned g = 0; g < 4; g++) begin
            if (bank_en_c[g]) begin
                out_o[g*8 +: 8] = 8'(1) << addr_i[2:0];
            end
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// 32 x 64 LEGv8 register file with X31 hardwired to zero and a same-cycle write-to-read bypass.
module regfile_wb
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     RegWrite,
    input  reg_idx_t WriteRegister,
    input  word_t    WriteData,
    input  reg_idx_t ReadRegister1,
    input  reg_idx_t ReadRegister2,
    output word_t    ReadData1,
    output word_t    ReadData2
);

    localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

    logic [NUM_REGS-1:0] we_c;
    word_t               regs_q [ZERO_REG];
    word_t               regs_d [ZERO_REG];
    word_vec_t           rf_c;
    word_t               raw1_c;
    word_t               raw2_c;

    regfile_wb_decoder5to32 u_dec (
        .write_i (RegWrite),
        .addr_i  (WriteRegister),
        .out_o   (we_c)
    );

    // Only X0..X30 have storage, so decoder output 31 never reaches a register.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < ZERO_REG; i++) begin
            if (we_c[i]) begin
                regs_d[i] = WriteData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rf_c = '0;
        for (int unsigned i = 0; i < ZERO_REG; i++) begin
            rf_c[i] = regs_q[i];
        end
    end

    assign raw1_c = mux32to1_64(rf_c, ReadRegister1);
    assign raw2_c = mux32to1_64(rf_c, ReadRegister2);

    // The decoder output at the read index doubles as the bypass hit; XZR and reset override it.
    always_comb begin
        ReadData1 = raw1_c;
        ReadData2 = raw2_c;
        if (we_c[ReadRegister1] && !reset) begin
            ReadData1 = WriteData;
        end
        if (we_c[ReadRegister2] && !reset) begin
            ReadData2 = WriteData;
        end
        if (ReadRegister1 == ZERO_IDX) begin
            ReadData1 = '0;
        end
        if (ReadRegister2 == ZERO_IDX) begin
            ReadData2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: literal checks per scenario plus a per-cycle compare against an array model.
module tb_regfile_wb;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] model [31];
    bit          model_valid = 0;

    localparam logic [63:0] C_X3   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] C_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    regfile_wb dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: registers update on the edge; X31 is never stored.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 31; i++) model[i] = 64'd0;
            model_valid = 1;
        end else if (RegWrite && WriteRegister != 5'd31) begin
            model[WriteRegister] = WriteData;
        end
    end

    function automatic logic [63:0] exp_read(input logic [4:0] rr);
        if (rr == 5'd31) return 64'd0;
        if (RegWrite && !reset && WriteRegister == rr) return WriteData;
        return model[rr];
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_rd1", ReadData1, exp_read(ReadRegister1));
            check("model_rd2", ReadData2, exp_read(ReadRegister2));
        end
    end

    // Drive one cycle's inputs just after the edge, then wait to the mid-cycle sample point.
    task automatic cyc(input logic rst, input logic rw, input logic [4:0] wr,
                       input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        reset         = rst;
        RegWrite      = rw;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        @(negedge clk);
    endtask

    task automatic expect2(input string name, input logic [63:0] e1, input logic [63:0] e2);
        check({name, "_rd1"}, ReadData1, e1);
        check({name, "_rd2"}, ReadData2, e2);
    endtask

    initial begin
        reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd5;
        WriteData     = 64'hDEAD;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd0;

        // Reset held for two edges with a competing write to X5.
        cyc(1'b1, 1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd0);
        expect2("rst_hold", 64'd0, 64'd0);
        cyc(1'b0, 1'b0, 5'd5, 64'd0, 5'd5, 5'd0);
        expect2("after_rst", 64'd0, 64'd0);

        // Basic writes, each visible through the bypass in its own cycle.
        cyc(1'b0, 1'b1, 5'd3, C_X3, 5'd3, 5'd4);
        expect2("wr_x3", C_X3, 64'd0);
        cyc(1'b0, 1'b1, 5'd4, C_ONES, 5'd3, 5'd4);
        expect2("wr_x4", C_X3, C_ONES);
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd4);
        expect2("rd_x3_x4", C_X3, C_ONES);
        for (int i = 0; i < 31; i++) begin
            if (i != 3 && i != 4) begin
                cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(30 - i));
                check("others_zero", ReadData1, 64'd0);
            end
        end

        // XZR: write ignored, reads zero during and after.
        cyc(1'b0, 1'b1, 5'd31, 64'h55, 5'd31, 5'd31);
        expect2("xzr_wr", 64'd0, 64'd0);
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd31);
        expect2("xzr_after", 64'd0, 64'd0);
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd0);
        expect2("xzr_no_side", C_X3, 64'd0);

        // Bypass on both ports to the same register.
        cyc(1'b0, 1'b1, 5'd7, 64'h10, 5'd7, 5'd7);
        expect2("x7_init", 64'h10, 64'h10);
        cyc(1'b0, 1'b1, 5'd7, 64'h20, 5'd7, 5'd7);
        expect2("bypass_x7", 64'h20, 64'h20);
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd7);
        expect2("x7_after", 64'h20, 64'h20);

        // Write disabled: no state change and no bypass.
        cyc(1'b0, 1'b0, 5'd9, 64'hAB, 5'd9, 5'd9);
        expect2("wdis", 64'd0, 64'd0);
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd9, 5'd9);
        expect2("wdis_after", 64'd0, 64'd0);

        // Reset mid-operation beats a simultaneous write and suppresses bypass.
        cyc(1'b0, 1'b1, 5'd12, 64'h77, 5'd0, 5'd0);
        expect2("x12_wr", 64'd0, 64'd0);
        cyc(1'b1, 1'b1, 5'd12, 64'h99, 5'd12, 5'd3);
        expect2("rst_mid", 64'h77, C_X3);
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd12, 5'd3);
        expect2("rst_mid_after", 64'd0, 64'd0);

        // Boundary indices X0 and X30, ports bypassing independently.
        cyc(1'b0, 1'b1, 5'd30, 64'hA5A5, 5'd0, 5'd30);
        expect2("x30_byp", 64'd0, 64'hA5A5);
        cyc(1'b0, 1'b1, 5'd0, 64'h5A5A, 5'd0, 5'd30);
        expect2("x0_byp", 64'h5A5A, 64'hA5A5);
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd30, 5'd0);
        expect2("x30_x0", 64'hA5A5, 64'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
